// File: rtl/mem_pkg.sv
// ---------------------------------------------------------------------------
// mem_pkg
// Definitions shared between the packet-buffer memory and its free-list
// allocator: default geometry, the allocator state encoding, the block index
// type and a pointer wrap helper for circular index arithmetic.
// No ports (package).
// ---------------------------------------------------------------------------
package mem_pkg;

    localparam int NUM_BLOCKS = 1024;
    localparam int ADDR_W     = $clog2(NUM_BLOCKS);

    typedef enum logic [0:0] {
        FL_INIT = 1'b0,
        FL_RUN  = 1'b1
    } fl_state_e;

    typedef logic [ADDR_W-1:0] blk_idx_t;

    // Advance a circular pointer by 'off' positions. Callers never pass an
    // offset larger than the ring size, so a single subtraction is enough
    // and the ring size need not be a power of two.
    function automatic int wrap_add(input int ptr, input int off, input int modulus);
        int sum_v;
        sum_v = ptr + off;
        if (sum_v >= modulus) begin
            sum_v = sum_v - modulus;
        end else begin
            sum_v = sum_v;
        end
        return sum_v;
    endfunction

endpackage

// File: rtl/fl_inuse_map.sv
// ---------------------------------------------------------------------------
// fl_inuse_map
// One bit per managed block: 1 while the block is held by a requester.
// Qualifies incoming frees (legal index, block currently in use, not a
// repeat of a lower-numbered free port this cycle), clears the bits of the
// qualified frees and sets the bits of the blocks granted this cycle.
// Set wins over clear, so an index freed and re-granted in the same cycle
// stays marked as in use.
//
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset (clears the map)
//   chk_en       1 when frees may be accepted at all
//   free_req     per free port strobe
//   free_idx     per free port index, packed NUM_FREE x IDX_W
//   set_en       per alloc port grant
//   set_idx      per alloc port granted index, packed NUM_ALLOC x IDX_W
//   qual         per free port: 1 when the free is accepted
// ---------------------------------------------------------------------------
module fl_inuse_map #(
    parameter int NUM_BLOCKS = 1024,
    parameter int IDX_W      = $clog2(NUM_BLOCKS),
    parameter int NUM_ALLOC  = 2,
    parameter int NUM_FREE   = 2
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          chk_en,
    input  logic [NUM_FREE-1:0]           free_req,
    input  logic [NUM_FREE*IDX_W-1:0]     free_idx,
    input  logic [NUM_ALLOC-1:0]          set_en,
    input  logic [NUM_ALLOC*IDX_W-1:0]    set_idx,
    output logic [NUM_FREE-1:0]           qual
);

    logic [NUM_BLOCKS-1:0] map_r;
    logic [NUM_BLOCKS-1:0] map_next_s;
    logic [NUM_FREE-1:0]   qual_s;

    // Accept a free only for an in-range, in-use index not already freed by
    // a lower-numbered port in the same cycle.
    always_comb begin
        logic [IDX_W-1:0] idx_v;
        logic             ok_v;
        qual_s = '0;
        idx_v  = '0;
        ok_v   = 1'b0;
        for (int j = 0; j < NUM_FREE; j++) begin
            idx_v = free_idx[j*IDX_W +: IDX_W];
            if (chk_en && free_req[j] && (int'(idx_v) < NUM_BLOCKS)) begin
                ok_v = map_r[idx_v];
            end else begin
                ok_v = 1'b0;
            end
            for (int k = 0; k < j; k++) begin
                if (free_req[k] && (free_idx[k*IDX_W +: IDX_W] == idx_v)) begin
                    ok_v = 1'b0;
                end else begin
                    ok_v = ok_v;
                end
            end
            qual_s[j] = ok_v;
        end
    end

    // Clear the bits of accepted frees, then set the bits of new grants.
    always_comb begin
        map_next_s = map_r;
        for (int j = 0; j < NUM_FREE; j++) begin
            if (qual_s[j]) begin
                map_next_s[free_idx[j*IDX_W +: IDX_W]] = 1'b0;
            end else begin
                map_next_s = map_next_s;
            end
        end
        for (int a = 0; a < NUM_ALLOC; a++) begin
            if (set_en[a]) begin
                map_next_s[set_idx[a*IDX_W +: IDX_W]] = 1'b1;
            end else begin
                map_next_s = map_next_s;
            end
        end
    end

    // Bitmap register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            map_r <= '0;
        end else begin
            map_r <= map_next_s;
        end
    end

    assign qual = qual_s;

endmodule

// File: rtl/fl_mp.sv
// ---------------------------------------------------------------------------
// fl_mp
// Multi-port free-list allocator for packet-buffer blocks. After reset the
// index FIFO fills itself with 0..NUM_BLOCKS-1 (one entry per cycle); then
// each cycle accepted frees are first handed straight to the lowest
// requesting alloc ports, remaining requesters pop from the FIFO head, and
// leftover frees are pushed at the tail.
//
// Ports:
//   clk, rst_n     clock, asynchronous active-low reset
//   alloc_req_i    per alloc port request (level, hold until granted)
//   alloc_gnt_o    per alloc port grant, one-cycle pulse
//   alloc_idx_o    granted index per port, packed NUM_ALLOC x IDX_W
//   free_req_i     per free port strobe
//   free_idx_i     returned index per port, packed NUM_FREE x IDX_W
//   free_cnt_o     registered free-block count
//   low_wm_o       registered, 1 when free_cnt_o < LOW_WM
//   init_done_o    1 once the FIFO has been initialised
//   err_o          one-cycle pulse: a free was dropped
//   err_idx_o      index of the lowest-numbered dropped free
// ---------------------------------------------------------------------------
module fl_mp #(
    parameter int NUM_BLOCKS = mem_pkg::NUM_BLOCKS,
    parameter int IDX_W      = $clog2(NUM_BLOCKS),
    parameter int CNT_W      = $clog2(NUM_BLOCKS + 1),
    parameter int NUM_ALLOC  = 2,
    parameter int NUM_FREE   = 2,
    parameter int LOW_WM     = 16
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_ALLOC-1:0]          alloc_req_i,
    output logic [NUM_ALLOC-1:0]          alloc_gnt_o,
    output logic [NUM_ALLOC*IDX_W-1:0]    alloc_idx_o,
    input  logic [NUM_FREE-1:0]           free_req_i,
    input  logic [NUM_FREE*IDX_W-1:0]     free_idx_i,
    output logic [CNT_W-1:0]              free_cnt_o,
    output logic                          low_wm_o,
    output logic                          init_done_o,
    output logic                          err_o,
    output logic [IDX_W-1:0]              err_idx_o
);

    import mem_pkg::*;

    fl_state_e                    state_r;
    fl_state_e                    state_next_s;

    logic [IDX_W-1:0]             fifo_r [NUM_BLOCKS];
    logic [IDX_W-1:0]             head_r;
    logic [IDX_W-1:0]             head_next_s;
    logic [IDX_W-1:0]             tail_r;
    logic [IDX_W-1:0]             tail_next_s;
    logic [IDX_W-1:0]             init_cnt_r;
    logic [IDX_W-1:0]             init_cnt_next_s;
    logic [CNT_W-1:0]             free_cnt_r;
    logic [CNT_W-1:0]             free_cnt_next_s;
    logic                         low_wm_r;
    logic                         low_wm_next_s;
    logic                         init_done_r;
    logic                         init_done_next_s;
    logic [NUM_ALLOC-1:0]         gnt_r;
    logic [NUM_ALLOC-1:0]         gnt_next_s;
    logic [NUM_ALLOC*IDX_W-1:0]   idx_r;
    logic [NUM_ALLOC*IDX_W-1:0]   idx_next_s;
    logic                         err_r;
    logic                         err_next_s;
    logic [IDX_W-1:0]             err_idx_r;
    logic [IDX_W-1:0]             err_idx_next_s;

    logic [NUM_FREE-1:0]          qual_s;
    logic [NUM_FREE-1:0]          wr_en_s;
    logic [NUM_FREE*IDX_W-1:0]    wr_addr_s;
    logic [NUM_FREE*IDX_W-1:0]    wr_data_s;
    logic                         chk_en_s;

    assign chk_en_s = (state_r == FL_RUN);

    fl_inuse_map #(
        .NUM_BLOCKS (NUM_BLOCKS),
        .IDX_W      (IDX_W),
        .NUM_ALLOC  (NUM_ALLOC),
        .NUM_FREE   (NUM_FREE)
    ) u_inuse_map (
        .clk      (clk),
        .rst_n    (rst_n),
        .chk_en   (chk_en_s),
        .free_req (free_req_i),
        .free_idx (free_idx_i),
        .set_en   (gnt_next_s),
        .set_idx  (idx_next_s),
        .qual     (qual_s)
    );

    // Next state, port arbitration and FIFO/pointer/count update.
    always_comb begin
        int   n_req_v;
        int   n_qual_v;
        int   n_byp_v;
        int   n_pop_v;
        int   n_push_v;
        int   rank_v;
        int   rank_q_v [NUM_FREE];
        logic found_v;

        state_next_s     = state_r;
        head_next_s      = head_r;
        tail_next_s      = tail_r;
        init_cnt_next_s  = init_cnt_r;
        free_cnt_next_s  = free_cnt_r;
        init_done_next_s = init_done_r;
        gnt_next_s       = '0;
        idx_next_s       = idx_r;
        err_next_s       = 1'b0;
        err_idx_next_s   = err_idx_r;
        wr_en_s          = '0;
        wr_addr_s        = '0;
        wr_data_s        = '0;
        n_req_v          = 0;
        n_qual_v         = 0;
        n_byp_v          = 0;
        n_pop_v          = 0;
        n_push_v         = 0;
        rank_v           = 0;
        found_v          = 1'b0;
        for (int j = 0; j < NUM_FREE; j++) begin
            rank_q_v[j] = 0;
        end

        // Any free not accepted is dropped; only the lowest such port is
        // reported. During INIT nothing qualifies, so every free lands here.
        for (int j = 0; j < NUM_FREE; j++) begin
            if (free_req_i[j] && !qual_s[j] && !found_v) begin
                found_v        = 1'b1;
                err_next_s     = 1'b1;
                err_idx_next_s = free_idx_i[j*IDX_W +: IDX_W];
            end else begin
                found_v = found_v;
            end
        end

        case (state_r)
            FL_INIT: begin
                wr_en_s[0]              = 1'b1;
                wr_addr_s[0 +: IDX_W]   = init_cnt_r;
                wr_data_s[0 +: IDX_W]   = init_cnt_r;
                if (int'(init_cnt_r) == NUM_BLOCKS - 1) begin
                    state_next_s     = FL_RUN;
                    init_cnt_next_s  = '0;
                    free_cnt_next_s  = CNT_W'(NUM_BLOCKS);
                    init_done_next_s = 1'b1;
                end else begin
                    init_cnt_next_s  = init_cnt_r + IDX_W'(1);
                end
            end

            FL_RUN: begin
                // Rank of each accepted free among the accepted ones.
                for (int j = 0; j < NUM_FREE; j++) begin
                    rank_q_v[j] = n_qual_v;
                    if (qual_s[j]) begin
                        n_qual_v = n_qual_v + 1;
                    end else begin
                        n_qual_v = n_qual_v;
                    end
                end
                for (int a = 0; a < NUM_ALLOC; a++) begin
                    if (alloc_req_i[a]) begin
                        n_req_v = n_req_v + 1;
                    end else begin
                        n_req_v = n_req_v;
                    end
                end

                n_byp_v = (n_req_v < n_qual_v) ? n_req_v : n_qual_v;
                n_pop_v = n_req_v - n_byp_v;
                if (n_pop_v > int'(free_cnt_r)) begin
                    n_pop_v = int'(free_cnt_r);
                end else begin
                    n_pop_v = n_pop_v;
                end
                n_push_v = n_qual_v - n_byp_v;

                // The r-th requester takes the r-th accepted free while they
                // last, then the FIFO entries in head order.
                for (int a = 0; a < NUM_ALLOC; a++) begin
                    if (alloc_req_i[a]) begin
                        if (rank_v < n_byp_v) begin
                            gnt_next_s[a] = 1'b1;
                            for (int j = 0; j < NUM_FREE; j++) begin
                                if (qual_s[j] && (rank_q_v[j] == rank_v)) begin
                                    idx_next_s[a*IDX_W +: IDX_W] = free_idx_i[j*IDX_W +: IDX_W];
                                end else begin
                                    idx_next_s = idx_next_s;
                                end
                            end
                        end else if ((rank_v - n_byp_v) < n_pop_v) begin
                            gnt_next_s[a] = 1'b1;
                            idx_next_s[a*IDX_W +: IDX_W] =
                                fifo_r[IDX_W'(wrap_add(int'(head_r), rank_v - n_byp_v, NUM_BLOCKS))];
                        end else begin
                            gnt_next_s[a] = 1'b0;
                        end
                        rank_v = rank_v + 1;
                    end else begin
                        rank_v = rank_v;
                    end
                end

                // Accepted frees not consumed by the bypass go to the tail.
                for (int j = 0; j < NUM_FREE; j++) begin
                    if (qual_s[j] && (rank_q_v[j] >= n_byp_v)) begin
                        wr_en_s[j]                   = 1'b1;
                        wr_addr_s[j*IDX_W +: IDX_W]  =
                            IDX_W'(wrap_add(int'(tail_r), rank_q_v[j] - n_byp_v, NUM_BLOCKS));
                        wr_data_s[j*IDX_W +: IDX_W]  = free_idx_i[j*IDX_W +: IDX_W];
                    end else begin
                        wr_en_s[j] = 1'b0;
                    end
                end

                head_next_s     = IDX_W'(wrap_add(int'(head_r), n_pop_v, NUM_BLOCKS));
                tail_next_s     = IDX_W'(wrap_add(int'(tail_r), n_push_v, NUM_BLOCKS));
                free_cnt_next_s = CNT_W'(int'(free_cnt_r) - n_pop_v + n_push_v);
            end

            default: begin
                state_next_s = FL_INIT;
            end
        endcase

        low_wm_next_s = (int'(free_cnt_next_s) < LOW_WM);
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= FL_INIT;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Pointers, counters and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_r      <= '0;
            tail_r      <= '0;
            init_cnt_r  <= '0;
            free_cnt_r  <= '0;
            low_wm_r    <= 1'b1;
            init_done_r <= 1'b0;
            gnt_r       <= '0;
            idx_r       <= '0;
            err_r       <= 1'b0;
            err_idx_r   <= '0;
        end else begin
            head_r      <= head_next_s;
            tail_r      <= tail_next_s;
            init_cnt_r  <= init_cnt_next_s;
            free_cnt_r  <= free_cnt_next_s;
            low_wm_r    <= low_wm_next_s;
            init_done_r <= init_done_next_s;
            gnt_r       <= gnt_next_s;
            idx_r       <= idx_next_s;
            err_r       <= err_next_s;
            err_idx_r   <= err_idx_next_s;
        end
    end

    // FIFO storage; contents are rebuilt by INIT, so no reset is needed.
    always_ff @(posedge clk) begin
        for (int j = 0; j < NUM_FREE; j++) begin
            if (wr_en_s[j]) begin
                fifo_r[wr_addr_s[j*IDX_W +: IDX_W]] <= wr_data_s[j*IDX_W +: IDX_W];
            end
        end
    end

    assign alloc_gnt_o = gnt_r;
    assign alloc_idx_o = idx_r;
    assign free_cnt_o  = free_cnt_r;
    assign low_wm_o    = low_wm_r;
    assign init_done_o = init_done_r;
    assign err_o       = err_r;
    assign err_idx_o   = err_idx_r;

endmodule

// File: tb/tb_fl_mp.sv
// ---------------------------------------------------------------------------
// tb_fl_mp
// Self-checking bench for fl_mp with NUM_BLOCKS=8, two alloc and two free
// ports, LOW_WM=2. Directed scenarios compare against known values; a
// random phase compares against a queue-based reference model of the
// free list.
// ---------------------------------------------------------------------------
module tb_fl_mp;

    localparam int NB = 8;
    localparam int NA = 2;
    localparam int NF = 2;
    localparam int LW = 2;
    localparam int IW = 3;
    localparam int CW = 4;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [NA-1:0]    alloc_req;
    logic [NA-1:0]    alloc_gnt;
    logic [NA*IW-1:0] alloc_idx;
    logic [NF-1:0]    free_req;
    logic [NF*IW-1:0] free_idx;
    logic [CW-1:0]    free_cnt;
    logic             low_wm;
    logic             init_done;
    logic             err;
    logic [IW-1:0]    err_idx;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    int        mq[$];
    bit        inuse [NB];
    int        init_left;
    logic [1:0] e_gnt;
    int        e_idx [2];
    int        e_cnt;
    bit        e_lw;
    bit        e_done;
    bit        e_err;
    int        e_eidx;

    fl_mp #(
        .NUM_BLOCKS (NB),
        .IDX_W      (IW),
        .CNT_W      (CW),
        .NUM_ALLOC  (NA),
        .NUM_FREE   (NF),
        .LOW_WM     (LW)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .alloc_req_i (alloc_req),
        .alloc_gnt_o (alloc_gnt),
        .alloc_idx_o (alloc_idx),
        .free_req_i  (free_req),
        .free_idx_i  (free_idx),
        .free_cnt_o  (free_cnt),
        .low_wm_o    (low_wm),
        .init_done_o (init_done),
        .err_o       (err),
        .err_idx_o   (err_idx)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic model_reset();
        mq.delete();
        for (int k = 0; k < NB; k++) inuse[k] = 1'b0;
        init_left = NB;
        e_gnt = 2'b00;
        e_idx[0] = 0;
        e_idx[1] = 0;
        e_cnt = 0;
        e_lw = 1'b1;
        e_done = 1'b0;
        e_err = 1'b0;
        e_eidx = 0;
    endtask

    // One clock edge of the free list, described as list operations.
    task automatic model_step(input logic [1:0] req, input logic [1:0] fr, input int fi0, input int fi1);
        int fi [2];
        int ql[$];
        bit ok;
        fi[0] = fi0;
        fi[1] = fi1;
        e_gnt = 2'b00;
        e_err = 1'b0;
        if (init_left > 0) begin
            for (int j = 0; j < 2; j++) begin
                if (fr[j] && !e_err) begin
                    e_err = 1'b1;
                    e_eidx = fi[j];
                end
            end
            init_left--;
            if (init_left == 0) begin
                for (int k = 0; k < NB; k++) mq.push_back(k);
                e_done = 1'b1;
            end
        end else begin
            for (int j = 0; j < 2; j++) begin
                ok = fr[j] && (fi[j] < NB) && inuse[fi[j]];
                if (j == 1 && fr[0] && fi[0] == fi[1]) ok = 1'b0;
                if (ok) ql.push_back(fi[j]);
                else if (fr[j] && !e_err) begin
                    e_err = 1'b1;
                    e_eidx = fi[j];
                end
            end
            foreach (ql[q]) inuse[ql[q]] = 1'b0;
            for (int a = 0; a < 2; a++) begin
                if (req[a]) begin
                    if (ql.size() > 0) begin
                        e_idx[a] = ql.pop_front();
                        e_gnt[a] = 1'b1;
                        inuse[e_idx[a]] = 1'b1;
                    end else if (mq.size() > 0) begin
                        e_idx[a] = mq.pop_front();
                        e_gnt[a] = 1'b1;
                        inuse[e_idx[a]] = 1'b1;
                    end
                end
            end
            while (ql.size() > 0) mq.push_back(ql.pop_front());
        end
        e_cnt = mq.size();
        e_lw = (e_cnt < LW);
    endtask

    // Drive one cycle of inputs, advance the clock and the model.
    task automatic cyc(input logic [1:0] req, input logic [1:0] fr, input int fi0, input int fi1);
        alloc_req = req;
        free_req  = fr;
        free_idx  = {IW'(fi1), IW'(fi0)};
        @(posedge clk);
        model_step(req, fr, fi0, fi1);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b1;
        alloc_req = '0;
        free_req = '0;
        free_idx = '0;
        #2 rst_n = 1'b0;
        model_reset();
        #1;
        n_checks++; if (alloc_gnt !== 2'b00) begin n_fail++; $display("FAIL reset_gnt got %b want 00", alloc_gnt); end
        n_checks++; if (alloc_idx !== 6'd0) begin n_fail++; $display("FAIL reset_idx got %h want 0", alloc_idx); end
        n_checks++; if (free_cnt !== 4'd0) begin n_fail++; $display("FAIL reset_cnt got %0d want 0", free_cnt); end
        n_checks++; if (low_wm !== 1'b1) begin n_fail++; $display("FAIL reset_lw got %b want 1", low_wm); end
        n_checks++; if (init_done !== 1'b0) begin n_fail++; $display("FAIL reset_done got %b want 0", init_done); end
        n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL reset_err got %b want 0", err); end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_init();
        for (int k = 1; k <= NB; k++) begin
            cyc(2'b11, 2'b00, 0, 0);
            n_checks++; if (alloc_gnt !== 2'b00) begin n_fail++; $display("FAIL init_gnt cyc %0d got %b want 00", k, alloc_gnt); end
            if (k < NB) begin
                n_checks++; if (init_done !== 1'b0) begin n_fail++; $display("FAIL init_early cyc %0d got %b want 0", k, init_done); end
            end else begin
                n_checks++; if (init_done !== 1'b1) begin n_fail++; $display("FAIL init_done got %b want 1", init_done); end
                n_checks++; if (free_cnt !== 4'd8) begin n_fail++; $display("FAIL init_cnt got %0d want 8", free_cnt); end
            end
        end
    endtask

    task automatic test_first_grant();
        cyc(2'b11, 2'b00, 0, 0);
        n_checks++; if (alloc_gnt !== 2'b11) begin n_fail++; $display("FAIL first_gnt got %b want 11", alloc_gnt); end
        n_checks++; if (alloc_idx !== {3'd1, 3'd0}) begin n_fail++; $display("FAIL first_idx got %h want 08", alloc_idx); end
        n_checks++; if (free_cnt !== 4'd6) begin n_fail++; $display("FAIL first_cnt got %0d want 6", free_cnt); end
        n_checks++; if (low_wm !== 1'b0) begin n_fail++; $display("FAIL first_lw got %b want 0", low_wm); end
    endtask

    task automatic test_back_to_back();
        logic [IW-1:0] w0;
        logic [IW-1:0] w1;
        for (int k = 0; k < 3; k++) begin
            cyc(2'b11, 2'b00, 0, 0);
            w0 = IW'(2 * k + 2);
            w1 = IW'(2 * k + 3);
            n_checks++; if (alloc_gnt !== 2'b11) begin n_fail++; $display("FAIL b2b_gnt cyc %0d got %b want 11", k, alloc_gnt); end
            n_checks++; if (alloc_idx !== {w1, w0}) begin n_fail++; $display("FAIL b2b_idx cyc %0d got %h want %h", k, alloc_idx, {w1, w0}); end
        end
        n_checks++; if (free_cnt !== 4'd0) begin n_fail++; $display("FAIL empty_cnt got %0d want 0", free_cnt); end
        n_checks++; if (low_wm !== 1'b1) begin n_fail++; $display("FAIL empty_lw got %b want 1", low_wm); end
        cyc(2'b01, 2'b00, 0, 0);
        n_checks++; if (alloc_gnt !== 2'b00) begin n_fail++; $display("FAIL empty_gnt got %b want 00", alloc_gnt); end
    endtask

    task automatic test_bypass();
        cyc(2'b10, 2'b01, 3, 0);
        n_checks++; if (alloc_gnt !== 2'b10) begin n_fail++; $display("FAIL byp_gnt got %b want 10", alloc_gnt); end
        n_checks++; if (alloc_idx[5:3] !== 3'd3) begin n_fail++; $display("FAIL byp_idx got %0d want 3", alloc_idx[5:3]); end
        n_checks++; if (free_cnt !== 4'd0) begin n_fail++; $display("FAIL byp_cnt got %0d want 0", free_cnt); end
        n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL byp_err got %b want 0", err); end
    endtask

    task automatic test_double_free();
        cyc(2'b00, 2'b01, 5, 0);
        n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL df1_err got %b want 0", err); end
        n_checks++; if (free_cnt !== 4'd1) begin n_fail++; $display("FAIL df1_cnt got %0d want 1", free_cnt); end
        cyc(2'b00, 2'b01, 5, 0);
        n_checks++; if (err !== 1'b1) begin n_fail++; $display("FAIL df2_err got %b want 1", err); end
        n_checks++; if (err_idx !== 3'd5) begin n_fail++; $display("FAIL df2_eidx got %0d want 5", err_idx); end
        n_checks++; if (free_cnt !== 4'd1) begin n_fail++; $display("FAIL df2_cnt got %0d want 1", free_cnt); end
        n_checks++; if (low_wm !== 1'b1) begin n_fail++; $display("FAIL df2_lw got %b want 1", low_wm); end
        cyc(2'b00, 2'b11, 6, 6);
        n_checks++; if (err !== 1'b1) begin n_fail++; $display("FAIL dup_err got %b want 1", err); end
        n_checks++; if (err_idx !== 3'd6) begin n_fail++; $display("FAIL dup_eidx got %0d want 6", err_idx); end
        n_checks++; if (free_cnt !== 4'd2) begin n_fail++; $display("FAIL dup_cnt got %0d want 2", free_cnt); end
        n_checks++; if (low_wm !== 1'b0) begin n_fail++; $display("FAIL dup_lw got %b want 0", low_wm); end
        // Port 0 frees 7 (accepted, bypassed to alloc 0); port 1 re-frees 5.
        cyc(2'b01, 2'b11, 7, 5);
        n_checks++; if (alloc_gnt !== 2'b01) begin n_fail++; $display("FAIL mix_gnt got %b want 01", alloc_gnt); end
        n_checks++; if (alloc_idx[2:0] !== 3'd7) begin n_fail++; $display("FAIL mix_idx got %0d want 7", alloc_idx[2:0]); end
        n_checks++; if (err !== 1'b1 || err_idx !== 3'd5) begin n_fail++; $display("FAIL mix_err got %b/%0d want 1/5", err, err_idx); end
        n_checks++; if (free_cnt !== 4'd2) begin n_fail++; $display("FAIL mix_cnt got %0d want 2", free_cnt); end
        cyc(2'b00, 2'b01, 4, 0);
        n_checks++; if (free_cnt !== 4'd3) begin n_fail++; $display("FAIL f4_cnt got %0d want 3", free_cnt); end
    endtask

    task automatic test_midrun_reset();
        #2 rst_n = 1'b0;
        #1;
        n_checks++; if (alloc_gnt !== 2'b00) begin n_fail++; $display("FAIL mrst_gnt got %b want 00", alloc_gnt); end
        n_checks++; if (alloc_idx !== 6'd0) begin n_fail++; $display("FAIL mrst_idx got %h want 0", alloc_idx); end
        n_checks++; if (free_cnt !== 4'd0) begin n_fail++; $display("FAIL mrst_cnt got %0d want 0", free_cnt); end
        n_checks++; if (low_wm !== 1'b1) begin n_fail++; $display("FAIL mrst_lw got %b want 1", low_wm); end
        n_checks++; if (init_done !== 1'b0) begin n_fail++; $display("FAIL mrst_done got %b want 0", init_done); end
        n_checks++; if (err_idx !== 3'd0) begin n_fail++; $display("FAIL mrst_eidx got %0d want 0", err_idx); end
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 1; k <= NB; k++) begin
            cyc(2'b11, 2'b00, 0, 0);
            n_checks++; if (alloc_gnt !== 2'b00) begin n_fail++; $display("FAIL reinit_gnt cyc %0d got %b want 00", k, alloc_gnt); end
        end
        n_checks++; if (init_done !== 1'b1) begin n_fail++; $display("FAIL reinit_done got %b want 1", init_done); end
        n_checks++; if (free_cnt !== 4'd8) begin n_fail++; $display("FAIL reinit_cnt got %0d want 8", free_cnt); end
        cyc(2'b00, 2'b01, 2, 0);
        n_checks++; if (err !== 1'b1 || err_idx !== 3'd2) begin n_fail++; $display("FAIL stale_free got %b/%0d want 1/2", err, err_idx); end
        n_checks++; if (free_cnt !== 4'd8) begin n_fail++; $display("FAIL stale_cnt got %0d want 8", free_cnt); end
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            cyc(2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                int'($urandom_range(0, NB - 1)), int'($urandom_range(0, NB - 1)));
            n_checks++; if (alloc_gnt !== e_gnt) begin n_fail++; $display("FAIL rnd_gnt cyc %0d got %b want %b", c, alloc_gnt, e_gnt); end
            for (int a = 0; a < NA; a++) begin
                if (e_gnt[a]) begin
                    n_checks++;
                    if (alloc_idx[a*IW +: IW] !== IW'(e_idx[a])) begin
                        n_fail++; $display("FAIL rnd_idx cyc %0d port %0d got %0d want %0d", c, a, alloc_idx[a*IW +: IW], e_idx[a]);
                    end
                end
            end
            n_checks++; if (free_cnt !== CW'(e_cnt)) begin n_fail++; $display("FAIL rnd_cnt cyc %0d got %0d want %0d", c, free_cnt, e_cnt); end
            n_checks++; if (low_wm !== e_lw) begin n_fail++; $display("FAIL rnd_lw cyc %0d got %b want %b", c, low_wm, e_lw); end
            n_checks++; if (err !== e_err) begin n_fail++; $display("FAIL rnd_err cyc %0d got %b want %b", c, err, e_err); end
            if (e_err) begin
                n_checks++; if (err_idx !== IW'(e_eidx)) begin n_fail++; $display("FAIL rnd_eidx cyc %0d got %0d want %0d", c, err_idx, e_eidx); end
            end
        end
    endtask

    initial begin
        test_reset();
        test_init();
        test_first_grant();
        test_back_to_back();
        test_bypass();
        test_double_free();
        test_midrun_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fl_mp.md
Name: fl_mp

Overview:
Parametrised multi-port free-list allocator for packet-buffer blocks. Hands out block indices to NUM_ALLOC requesters and accepts returns from NUM_FREE releasers in the same cycle. Adds a self-initialising index FIFO, free-count and low-watermark reporting, and a double-free / illegal-index guard. Sits between the ingress writers (alloc) and the egress readers (free) of the shared packet memory.

Parameters:
NUM_BLOCKS, 1024, number of managed blocks; valid indices are 0..NUM_BLOCKS-1. Any value ≥2; a power of 2 is not required.
IDX_W, $clog2(NUM_BLOCKS), block index width.
CNT_W, $clog2(NUM_BLOCKS+1), free-count width.
NUM_ALLOC, 2, allocation ports; must be ≥1.
NUM_FREE, 2, free ports; must be ≥1.
LOW_WM, 16, low-watermark threshold; must be ≥1.

Ports:
clk  in  1  clock
rst_n  in  1  reset, asynchronous, active-low
alloc_req_i  in  NUM_ALLOC  per-port allocation request, level
alloc_gnt_o  out  NUM_ALLOC  per-port grant, 1-cycle pulse
alloc_idx_o  out  NUM_ALLOC×IDX_W  granted index, valid when the matching gnt is 1
free_req_i  in  NUM_FREE  per-port free strobe
free_idx_i  in  NUM_FREE×IDX_W  index being returned
free_cnt_o  out  CNT_W  registered free-block count
low_wm_o  out  1  registered, 1 when free_cnt_o < LOW_WM
init_done_o  out  1  1 once the FIFO is initialised
err_o  out  1  1-cycle pulse: a free was dropped
err_idx_o  out  IDX_W  index of the dropped free

Behaviour:
- Reset values:
  - gnt = 0, alloc_idx = 0, free_cnt = 0, low_wm = 1, init_done = 0, err = 0, err_idx = 0.
  - FSM = INIT; head = tail = 0; init counter = 0; in-use bitmap all 0.
- INIT state:
  - Writes fifo[k] = k, one entry per cycle, for k = 0..NUM_BLOCKS-1.
  - After the last write: go to RUN, free_cnt = NUM_BLOCKS, init_done = 1.
  - This takes exactly NUM_BLOCKS cycles after reset release.
  - alloc_req_i is ignored (no grants).
  - Every free_req_i is dropped and flagged via err_o.
- RUN state, per cycle, frees are qualified first:
  - Drop a free if its index is ≥ NUM_BLOCKS.
  - Drop a free if its in-use bit is 0 (double free).
  - Drop a free if its index equals the index on a lower-numbered free port in the same cycle.
  - err_o/err_idx_o report the lowest-numbered dropped port; other drops that cycle are not reported.
- Allocation order:
  - Allocs are served in ascending port order.
  - Bypass first: qualified frees of this cycle feed the lowest requesting alloc ports, also in ascending port order.
  - Remaining requesters pop from the FIFO head, in order.
  - Requests beyond the available count get no grant that cycle. The requester must hold alloc_req_i.
- Leftover qualified frees are pushed at the tail, in ascending port order.
- Pointer and count update:
  - head/tail advance by pops/pushes, with explicit wrap at NUM_BLOCKS.
  - free_cnt_next = free_cnt − pops + pushes; bypassed frees are count-neutral.
  - Overflow is impossible: the bitmap guard ensures at most NUM_BLOCKS entries.
- Latency: request in cycle N → alloc_gnt_o/alloc_idx_o in cycle N+1, held for exactly one cycle. Back-to-back grants are allowed every cycle.
- Bitmap: the bit is set in the cycle a grant is issued and cleared on a qualified free. A bypassed index is cleared and re-set in the same cycle, so it ends up 1.
- low_wm_o is computed from free_cnt_next and registered alongside free_cnt_o.
- Reset asserted mid-operation: all state returns to reset values immediately and INIT restarts. Outstanding allocations are forgotten.

Decomposition:
- mem_pkg holds:
  - NUM_BLOCKS and ADDR_W shared with the buffer memory;
  - an fl_state_e enum {FL_INIT, FL_RUN};
  - the blk_idx_t typedef.
- One sub-module, fl_inuse_map:
  - holds the NUM_BLOCKS-bit in-use bitmap;
  - has NUM_ALLOC set ports and NUM_FREE check/clear ports;
  - outputs a per-free-port qualified vector.
- FIFO storage, pointers and port arbitration stay in fl_mp.

Test Plan (NUM_BLOCKS=8, NUM_ALLOC=2, NUM_FREE=2, LOW_WM=2):
1. Release reset and hold alloc_req=2'b11 → no grant for 8 cycles. Then init_done=1, free_cnt=8, and grants start the next cycle.
2. After init, one cycle of alloc_req=2'b11 → next cycle gnt=2'b11, idx0=0, idx1=1, free_cnt=6, low_wm=0.
3. Allocate all 8 blocks → free_cnt=0, low_wm=1. The next alloc_req=2'b01 gets gnt=0.
4. With free_cnt=0, in one cycle send free port0 idx 3 and alloc_req=2'b10 → next cycle gnt[1]=1, idx1=3, free_cnt stays 0, err=0.
5. Free idx 5, then free idx 5 again → the second free gives err=1 with err_idx=5, and free_cnt rises by only 1. Freeing idx 6 on both ports in one cycle → err=1 with err_idx=6, and free_cnt +1.
6. Pull rst_n low mid-run with 5 blocks allocated → outputs at reset values immediately. After release, init_done again after 8 cycles with free_cnt=8; a free of idx 2 is then flagged as err.
